bcd_digit: RTL and testbench
============================

# bcd_digit

Single-decade BCD counter cell for the stopwatch datapath. Each clock edge with `c_in` high advances the stored digit by one. The digit wraps from its maximum value back to 0. A carry is produced for the next, more significant cell. Cells are cascaded by wiring `c_out` of one cell to `c_in` of the next, and all cells share one clock, to build the seconds/minutes display chain.

## Interface
- `MAX_VALUE`, default 9: terminal count. Legal range 1..9; use 5 for tens-of-seconds/minutes cells.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; `reset`=0 forces the digit to 0 immediately.
- `c_in`  input  1  count enable / carry-in from the less significant cell (or from the tick source for the least significant cell).
- `digit`  output  4  current BCD value, 0..MAX_VALUE, registered.
- `c_out`  output  1  carry to the next cell, combinational.

## Operation
- The state is a 4-bit register `digit`.
- Reset: while `reset`=0, `digit`=0 asynchronously, independent of `clk` and `c_in`. `c_out`=0 during reset because `digit`≠MAX_VALUE (MAX_VALUE≥1).
- Counting (on the rising `clk` edge with `reset`=1):
  - `c_in`=0: `digit` holds.
  - `c_in`=1 and `digit`<MAX_VALUE: `digit` ← `digit`+1.
  - `c_in`=1 and `digit`=MAX_VALUE: `digit` ← 0 (wrap).
- Carry: `c_out` = `c_in` AND (`digit` == MAX_VALUE), with no register. This ripple-enable lets a cascaded chain roll over all cells on the same edge.
- Illegal states (`digit`>MAX_VALUE, only reachable by an upset): on the next edge with `c_in`=1, `digit` ← 0. `c_out` stays 0 while the digit is in an illegal state.
- `digit` never takes values outside 0..MAX_VALUE in legal operation. Arithmetic is 4-bit unsigned.

## Timing
- `digit` changes only on the rising `clk` edge, or asynchronously on the falling edge of `reset`.
- Latency from `c_in` to the `digit` update is one clock edge.
- Latency from `c_in`/`digit` to `c_out` is combinational, within the same cycle. `c_out` is high for exactly the cycle(s) in which `c_in`=1 and `digit`=MAX_VALUE.
- Reset deassertion is sampled like any synchronous input. The first count occurs on the first rising edge with `reset`=1 and `c_in`=1.
- Reset asserted mid-count: `digit` clears at once. Any pending carry is dropped, and `c_out` falls in the same instant.
- Holding `c_in`=1 continuously gives a period of MAX_VALUE+1 clocks. `c_out` then pulses high one cycle per period, in the cycle where `digit`=MAX_VALUE.
- Cascade: the chain length is limited only by the combinational carry path. No additional pipeline stages.

## Test plan
- Reset: drive `reset`=0 with `c_in`=1 and a free-running clk (20 ns period) -> `digit`=0 and `c_out`=0 throughout. Drop `reset` mid-count at `digit`=6 -> `digit`=0 immediately, without waiting for a clock edge.
- Free count: release reset and hold `c_in`=1 -> `digit` steps 0,1,…,9,0 on successive edges. `c_out`=1 only while `digit`=9, which is one cycle in every 10.
- Hold: at `digit`=4, set `c_in`=0 for 5 edges -> `digit` stays 4 and `c_out`=0. Re-enable -> the next edge gives 5.
- Carry gating: park at `digit`=9 with `c_in`=0 -> `c_out`=0. Raise `c_in` -> `c_out`=1 combinationally, then `digit`=0 and `c_out`=0 after the edge.
- MAX_VALUE=5 instance -> sequence 0..5,0. `c_out` is high while `digit`=5 and `c_in`=1.
- Cascade two cells (units MAX 9 feeding tens MAX 5) with `c_in`=1 -> after 59 edges the outputs read 5/9. Edge 60 -> both cells read 0 together, and the tens `c_out` pulsed in the preceding cycle.

Source files
------------

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the stopwatch counter chain.
// The digit advances on each clock edge where c_in is high. It wraps from
// MAX_VALUE to 0. c_out is a combinational ripple enable, so a cascaded chain
// rolls over every cell on the same edge without extra pipeline stages.
module bcd_digit #(
    parameter int unsigned MAX_VALUE = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       c_in,
    output logic [3:0] digit,
    output logic       c_out
);

    localparam logic [3:0] MAX_DIGIT = 4'(MAX_VALUE);

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       at_max;

    // Next-digit and carry. Any value at or above MAX_DIGIT wraps to 0, so an
    // upset into an illegal code is flushed on the next enabled edge. c_out
    // only matches the exact terminal count, so it stays low in illegal codes.
    always_comb begin
        digit_d = digit_q;
        at_max  = (digit_q == MAX_DIGIT);
        if (c_in) begin
            if (digit_q < MAX_DIGIT) begin
                digit_d = digit_q + 4'd1;
            end else begin
                digit_d = 4'd0;
            end
        end
        c_out = c_in & at_max;
    end

    // Digit register, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: tb/tb_bcd_digit.sv
// Directed bench for bcd_digit: a MAX 9 cell, a MAX 5 cell and a two-cell
// units/tens cascade, all sharing clock and reset.
module tb_bcd_digit;

    logic       clk;
    logic       reset;
    logic       c_in9;
    logic       c_in5;
    logic       c_casc;
    logic [3:0] digit9;
    logic       c_out9;
    logic [3:0] digit5;
    logic       c_out5;
    logic [3:0] units;
    logic       units_c_out;
    logic [3:0] tens;
    logic       tens_c_out;

    int total;
    int bad;
    int tens_pulses;

    bcd_digit #(.MAX_VALUE(9)) u_dut9 (
        .clk(clk), .reset(reset), .c_in(c_in9), .digit(digit9), .c_out(c_out9)
    );

    bcd_digit #(.MAX_VALUE(5)) u_dut5 (
        .clk(clk), .reset(reset), .c_in(c_in5), .digit(digit5), .c_out(c_out5)
    );

    bcd_digit #(.MAX_VALUE(9)) u_units (
        .clk(clk), .reset(reset), .c_in(c_casc), .digit(units), .c_out(units_c_out)
    );

    bcd_digit #(.MAX_VALUE(5)) u_tens (
        .clk(clk), .reset(reset), .c_in(units_c_out), .digit(tens), .c_out(tens_c_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        tens_pulses = 0;
        reset       = 1'b0;
        c_in9       = 1'b1;
        c_in5       = 1'b1;
        c_casc      = 1'b1;

        // Reset held with c_in high and the clock running.
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("rst_digit9", digit9, 4'd0);
            chk("rst_cout9", {3'b0, c_out9}, 4'd0);
            chk("rst_digit5", digit5, 4'd0);
            chk("rst_units", units, 4'd0);
        end

        // Release reset with only the MAX 9 cell enabled.
        c_in5  = 1'b0;
        c_casc = 1'b0;
        reset  = 1'b1;
        #1;
        chk("free_start", digit9, 4'd0);
        chk("free_start_cout", {3'b0, c_out9}, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            edge_step();
            chk("free_digit", digit9, 4'(i % 10));
            chk("free_cout", {3'b0, c_out9}, ((i % 10) == 9) ? 4'd1 : 4'd0);
        end

        // Count up to 4, then hold.
        for (int i = 0; i < 4; i++) edge_step();
        chk("pre_hold", digit9, 4'd4);
        c_in9 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            chk("hold_digit", digit9, 4'd4);
            chk("hold_cout", {3'b0, c_out9}, 4'd0);
        end
        c_in9 = 1'b1;
        edge_step();
        chk("resume", digit9, 4'd5);

        // Asynchronous reset mid-count at 6, between clock edges.
        edge_step();
        chk("pre_async", digit9, 4'd6);
        #3 reset = 1'b0;
        #1;
        chk("async_digit", digit9, 4'd0);
        chk("async_cout", {3'b0, c_out9}, 4'd0);
        edge_step();
        chk("async_hold", digit9, 4'd0);
        reset = 1'b1;

        // Carry gating at the terminal count.
        for (int i = 0; i < 9; i++) edge_step();
        chk("park9", digit9, 4'd9);
        chk("park9_cout_en", {3'b0, c_out9}, 4'd1);
        c_in9 = 1'b0;
        #1;
        chk("park9_cout_dis", {3'b0, c_out9}, 4'd0);
        edge_step();
        chk("park9_hold", digit9, 4'd9);
        c_in9 = 1'b1;
        #1;
        chk("gate_cout_rise", {3'b0, c_out9}, 4'd1);
        edge_step();
        chk("gate_wrap", digit9, 4'd0);
        chk("gate_cout_fall", {3'b0, c_out9}, 4'd0);
        c_in9 = 1'b0;

        // MAX 5 cell: 0..5,0.
        c_in5 = 1'b1;
        #1;
        chk("m5_start", digit5, 4'd0);
        for (int i = 1; i <= 6; i++) begin
            edge_step();
            chk("m5_digit", digit5, 4'(i % 6));
            chk("m5_cout", {3'b0, c_out5}, ((i % 6) == 5) ? 4'd1 : 4'd0);
        end
        c_in5 = 1'b0;
        #1;
        chk("m5_cout_off", {3'b0, c_out5}, 4'd0);

        // Cascade units (MAX 9) into tens (MAX 5).
        c_casc = 1'b1;
        #1;
        chk("casc_start_u", units, 4'd0);
        chk("casc_start_t", tens, 4'd0);
        for (int n = 1; n <= 59; n++) begin
            edge_step();
            if (tens_c_out) tens_pulses++;
        end
        chk("casc59_units", units, 4'd9);
        chk("casc59_tens", tens, 4'd5);
        chk("casc59_tcout", {3'b0, tens_c_out}, 4'd1);
        chk("casc_pulse_count", 4'(tens_pulses), 4'd1);
        edge_step();
        chk("casc60_units", units, 4'd0);
        chk("casc60_tens", tens, 4'd0);
        chk("casc60_tcout", {3'b0, tens_c_out}, 4'd0);
        edge_step();
        chk("casc61_units", units, 4'd1);
        chk("casc61_tens", tens, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
